sn_to_bn: RTL and testbench
===========================

SN_TO_BN -- requirements
Module: sn_to_bn

Interface
REQ-001 Parameter: LEN, 16, stream length in bits per conversion window; power of two, 2..256.
REQ-002 Parameter: CW, $clog2(LEN+1), width of the full ones-count output.
REQ-003 Parameter: XW, $clog2(LEN), width of the saturated binary output.
REQ-004 Port: i_clk_s2b  input  1  single clock; all state updates on its rising edge.
REQ-005 Port: i_rst_s2b  input  1  reset, asynchronous, active-high.
REQ-006 Port: i_start_s2b  input  1  window start; the bit on i_sn_bit in the same cycle is sample 0.
REQ-007 Port: i_stop_s2b  input  1  abort current window.
REQ-008 Port: i_sn_bit  input  1  stochastic bit stream from the SNG stage.
REQ-009 Port: i_ready_s2b  input  1  consumer accepts result.
REQ-010 Port: o_count  output  CW  number of 1s sampled in the window (0..LEN).
REQ-011 Port: o_x_bn  output  XW  o_count saturated to LEN-1.
REQ-012 Port: o_valid  output  1  result valid.
REQ-013 Port: o_aborted  output  1  result came from a stopped (partial) window.
REQ-014 Port: o_busy  output  1  window in progress.

Function
REQ-015 The block SHALL implement a registered FSM with states IDLE, ACC, DONE.
REQ-016 IDLE: i_start_s2b=1 SHALL load acc = i_sn_bit, sample counter = 1, go to ACC; i_stop_s2b is ignored in IDLE.
REQ-017 ACC: each cycle with i_stop_s2b=0 SHALL add i_sn_bit to acc and increment the sample counter.
REQ-018 ACC: when the cycle's sample is the LEN-th (counter = LEN-1 before the update), FSM SHALL go to DONE with o_aborted=0.
REQ-019 ACC: i_stop_s2b=1 SHALL go to DONE with o_aborted=1; that cycle's i_sn_bit SHALL NOT be counted; stop overrides the LEN-th-sample completion in the same cycle.
REQ-020 ACC: i_start_s2b SHALL be ignored (no restart).
REQ-021 DONE: o_valid=1, o_count/o_x_bn/o_aborted held stable until the handshake cycle (o_valid & i_ready_s2b).
REQ-022 Handshake cycle SHALL return to IDLE; o_valid SHALL drop the following cycle.
REQ-023 i_start_s2b during DONE, including the handshake cycle, SHALL be ignored; the producer re-issues start from IDLE.
REQ-024 Latency: for an uninterrupted window started at cycle T, o_valid SHALL be 1 from cycle T+LEN.
REQ-025 o_busy SHALL be 1 exactly when the state is ACC.
REQ-026 acc SHALL be CW bits wide and never wrap (maximum LEN); o_x_bn = (acc == LEN) ? LEN-1 : acc[XW-1:0].
REQ-027 o_count, o_x_bn, o_aborted SHALL be driven from registers (no combinational path from inputs); outside DONE they hold the last completed result.
REQ-028 An illegal state encoding SHALL return to IDLE on the next clock.

Reset
REQ-029 Assertion of i_rst_s2b SHALL asynchronously force state IDLE, acc=0, sample counter=0, o_count=0, o_x_bn=0, o_valid=0, o_aborted=0, o_busy=0.
REQ-030 Reset mid-window or in DONE SHALL discard the partial or pending result; the first clock after deassertion behaves as IDLE.

Verification
REQ-031 LEN=16, start with stream of 16 ones, ready=1 -> at T+16 o_valid=1, o_count=16, o_x_bn=15, o_aborted=0; o_valid=0 at T+17.
REQ-032 Stream of SNG encoding of x=4'b1010 (8 ones of bit3, 2 of bit1) -> o_count=10, o_x_bn=10; all-zero stream -> o_count=0.
REQ-033 Stream all ones, i_stop_s2b at sample 5 (samples 0..4 counted) -> o_count=5, o_aborted=1; stop on sample 15 -> o_count=15, o_aborted=1.
REQ-034 Hold i_ready_s2b=0 for 7 cycles after completion while toggling i_start_s2b/i_sn_bit -> outputs stable, no restart; ready=1 -> return to IDLE, next start accepted.
REQ-035 Assert i_rst_s2b asynchronously (between clock edges) at sample 9 -> all outputs 0 immediately; new window after release counts from 0 with correct result.
REQ-036 Back-to-back windows (start in first IDLE cycle after the handshake), random streams -> every o_count equals the reference popcount of its window.

Source files
------------

// File: rtl/sn_to_bn.sv
// sn_to_bn: counts the ones of a LEN-bit stochastic window and presents the count with a valid/ready handshake
module sn_to_bn #(
  parameter int LEN = 16,
  parameter int CW  = $clog2(LEN+1),
  parameter int XW  = $clog2(LEN)
) (
  input  logic          i_clk_s2b,
  input  logic          i_rst_s2b,
  input  logic          i_start_s2b,
  input  logic          i_stop_s2b,
  input  logic          i_sn_bit,
  input  logic          i_ready_s2b,
  output logic [CW-1:0] o_count,
  output logic [XW-1:0] o_x_bn,
  output logic          o_valid,
  output logic          o_aborted,
  output logic          o_busy
);
  typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, DONE = 2'd2} state_t;
  state_t state, state_nx;
  logic [CW-1:0] acc, cnt, acc_add, res;
  logic fin;
  assign acc_add = acc + CW'(i_sn_bit);
  // a stopped window drops the bit sampled in the stop cycle
  assign res = i_stop_s2b ? acc : acc_add;
  assign fin = (state == ACC) && (i_stop_s2b || cnt == CW'(LEN-1));
  assign o_valid = state == DONE;
  assign o_busy = state == ACC;
  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE:    state_nx = i_start_s2b ? ACC : IDLE;
      ACC:     state_nx = fin ? DONE : ACC;
      DONE:    state_nx = i_ready_s2b ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge i_clk_s2b or posedge i_rst_s2b) begin
    if (i_rst_s2b) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      o_count   <= '0;
      o_x_bn    <= '0;
      o_aborted <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && i_start_s2b) begin
        acc <= CW'(i_sn_bit);
        cnt <= CW'(1);
      end else if (state == ACC && !i_stop_s2b) begin
        acc <= acc_add;
        cnt <= cnt + CW'(1);
      end
      if (fin) begin
        o_count   <= res;
        o_x_bn    <= (res == CW'(LEN)) ? XW'(LEN-1) : res[XW-1:0];
        o_aborted <= i_stop_s2b;
      end
    end
  end
endmodule

// File: tb/tb_sn_to_bn.sv
// tb_sn_to_bn: directed and random windows against a popcount scoreboard
module tb_sn_to_bn;
  localparam int LEN = 16;
  localparam int CW = $clog2(LEN+1);
  localparam int XW = $clog2(LEN);
  logic clk = 0, rst = 1, start = 0, stop = 0, sn = 0, ready = 0;
  logic [CW-1:0] count;
  logic [XW-1:0] x_bn;
  logic valid, aborted, busy;
  typedef struct packed {logic [CW-1:0] c; logic a;} exp_t;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  sn_to_bn #(.LEN(LEN)) dut (
    .i_clk_s2b(clk), .i_rst_s2b(rst), .i_start_s2b(start), .i_stop_s2b(stop),
    .i_sn_bit(sn), .i_ready_s2b(ready), .o_count(count), .o_x_bn(x_bn),
    .o_valid(valid), .o_aborted(aborted), .o_busy(busy)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_count"}, 32'(count), 0);
    chk({tag, "_xbn"}, 32'(x_bn), 0);
    chk({tag, "_valid"}, 32'(valid), 0);
    chk({tag, "_aborted"}, 32'(aborted), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask
  // drives one window from the current negedge; stop_at<0 means uninterrupted
  task automatic window(input logic [LEN-1:0] bits, input int stop_at, input int hold, input string tag);
    exp_t e;
    int n;
    int c;
    int xe;
    n = (stop_at < 0) ? LEN : stop_at;
    c = 0;
    for (int i = 0; i < n; i++) c += int'(bits[i]);
    e.c = CW'(c);
    e.a = stop_at >= 0;
    q.push_back(e);
    for (int i = 0; i <= n && i < LEN; i++) begin
      start = (i == 0);
      sn = bits[i];
      stop = (i == stop_at);
      ready = 0;
      @(negedge clk);
      if (i == 0) chk({tag, "_busy"}, 32'(busy), 1);
    end
    start = 0;
    stop = 0;
    sn = 0;
    chk({tag, "_valid"}, 32'(valid), 1);
    chk({tag, "_busy_done"}, 32'(busy), 0);
    e = q.pop_front();
    xe = (int'(e.c) == LEN) ? LEN-1 : int'(e.c);
    chk({tag, "_count"}, 32'(count), 32'(e.c));
    chk({tag, "_xbn"}, 32'(x_bn), 32'(xe));
    chk({tag, "_aborted"}, 32'(aborted), 32'(e.a));
    for (int h = 0; h < hold; h++) begin
      start = h[0];
      sn = ~h[0];
      @(negedge clk);
      chk({tag, "_hold_valid"}, 32'(valid), 1);
      chk({tag, "_hold_busy"}, 32'(busy), 0);
      chk({tag, "_hold_count"}, 32'(count), 32'(e.c));
      chk({tag, "_hold_aborted"}, 32'(aborted), 32'(e.a));
    end
    ready = 1;
    start = 1;
    @(negedge clk);
    ready = 0;
    start = 0;
    chk({tag, "_valid_drop"}, 32'(valid), 0);
    chk({tag, "_idle"}, 32'(busy), 0);
    chk({tag, "_count_kept"}, 32'(count), 32'(e.c));
  endtask
  initial begin
    #1 chk_zero("reset");
    @(negedge clk);
    rst = 0;
    stop = 1;
    @(negedge clk);
    stop = 0;
    chk("stop_in_idle", 32'(valid), 0);
    window(16'hFFFF, -1, 0, "all_ones");
    window(16'h0AFF, -1, 0, "x1010");
    window(16'h0000, -1, 0, "all_zero");
    window(16'hFFFF, 5, 0, "stop5");
    window(16'hFFFF, 15, 0, "stop15");
    window(16'h5A3C, -1, 7, "hold7");
    window(16'h1234, -1, 0, "after_hold");
    start = 1;
    sn = 1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      start = 0;
    end
    #2 rst = 1;
    #1 chk_zero("async_rst");
    @(negedge clk);
    rst = 0;
    window(16'h00F0, -1, 0, "post_rst");
    for (int k = 0; k < 6; k++) window(LEN'($urandom), -1, k % 2, "rand");
    chk("queue_empty", 32'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
